// File: rtl/sub_serial_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sub_serial_pkg;

  // Default operand/result width.
  localparam int SUB_SERIAL_WIDTH = 8;

  // Controller state encoding, 2 bits wide.
  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SUB  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/sub_serial_fs.sv
// 1-bit full subtractor: d = a - b - bin, with borrow out.
// Latency: combinational.
// Backpressure: none.
module sub_serial_fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor: out = (a - b) mod 2^WIDTH, one bit per cycle, LSB first.
// Latency: done rises WIDTH cycles after en is sampled in IDLE; one result per WIDTH+2 cycles.
// Backpressure: four-phase en/done level handshake; en ignored while busy.
// Optional: define SUB_SERIAL_SAT_EN to floor a negative result to zero (borrow still reported).
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = SUB_SERIAL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CW-1:0]    count;
  logic             brw;
  logic             fs_d;
  logic             fs_bout;
  logic             last_bit;

  // Single bit slice; the shift registers present the current LSB pair.
  sub_serial_fs u_fs (
    .a    (a_reg[0]),
    .b    (b_reg[0]),
    .bin  (brw),
    .d    (fs_d),
    .bout (fs_bout)
  );

  assign last_bit = (count == LAST);

  // Controller: start on en in IDLE, run WIDTH bit steps, hold DONE until en drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (en) state <= ST_SUB;
        ST_SUB:  if (last_bit) state <= ST_DONE;
        ST_DONE: if (!en) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Datapath: capture operands on start, then shift one difference bit in per SUB cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      count <= '0;
      brw   <= 1'b0;
      out   <= '0;
    end else if (state == ST_IDLE) begin
      if (en) begin
        a_reg <= a;
        b_reg <= b;
        count <= '0;
        brw   <= 1'b0;
        out   <= '0;
      end
    end else if (state == ST_SUB) begin
      a_reg <= a_reg >> 1;
      b_reg <= b_reg >> 1;
      brw   <= fs_bout;
      count <= count + 1'b1;
`ifdef SUB_SERIAL_SAT_EN
      // A final borrow means a < b: clamp to zero instead of wrapping.
      if (last_bit && fs_bout) begin
        out <= '0;
      end else begin
        out <= {fs_d, out[WIDTH-1:1]};
      end
`else
      out <= {fs_d, out[WIDTH-1:1]};
`endif
    end
  end

  // All flags decode from registered state/borrow only.
  assign busy   = (state == ST_SUB);
  assign done   = (state == ST_DONE);
  assign borrow = brw;

endmodule

// File: tb/tb_sub_serial.sv
// Randomised and directed bench for sub_serial, checked every cycle against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sub_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic [W-1:0] out;
  logic         borrow;
  logic         busy;
  logic         done;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_on      = 1'b0;

  sub_serial #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .a      (a),
    .b      (b),
    .out    (out),
    .borrow (borrow),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 computing, 2 result presented.
  // During computing, after k bits the register holds the low k difference bits
  // at its top k positions, so out = diff << (W - k).
  int           m_phase = 0;
  int           m_k     = 0;
  logic [W-1:0] m_diff  = '0;
  logic [W-1:0] m_out   = '0;
  bit           m_brw   = 1'b0;
  bit           m_bv    = 1'b1;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_out   = '0;
      m_brw   = 1'b0;
      m_bv    = 1'b1;
    end else begin
      case (m_phase)
        0: if (en) begin
          m_diff  = a - b;
          m_brw   = (a < b);
          m_bv    = 1'b0;
          m_k     = 0;
          m_out   = '0;
          m_phase = 1;
        end
        1: begin
          m_k++;
          m_out = W'(m_diff << (W - m_k));
          if (m_k == W) begin
`ifdef SUB_SERIAL_SAT_EN
            if (m_brw) m_out = '0;
`endif
            m_bv    = 1'b1;
            m_phase = 2;
          end
        end
        default: if (!en) m_phase = 0;
      endcase
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", busy, (m_phase == 1));
      check("done", done, (m_phase == 2));
      check("out", out, m_out);
      if (m_bv) check("borrow", borrow, m_brw);
    end
  end

  // One operation: present operands with en, optionally drop en right after the
  // start edge, scramble a/b during SUB, measure done latency, hold, then release.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit pulse, input int hold);
    int k;
    logic [W-1:0] out_at_done;
    @(posedge clk); #1;
    a = av; b = bv; en = 1'b1;
    @(posedge clk); #1;            // E0 has just been sampled
    if (pulse) en = 1'b0;
    a = W'($urandom); b = W'($urandom);
    k = 0;
    while (!done && k < 4 * W) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_seen", done, 1);
    check("latency", k, W);
    out_at_done = out;
    if (!pulse) begin
      repeat (hold) begin
        @(posedge clk); #1;
        check("done_held", done, 1);
        check("out_stable", out, out_at_done);
      end
      en = 1'b0;
    end
    @(posedge clk); #1;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    check("rst_out", out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_borrow", borrow, 0);
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int r;

    repeat (2) @(posedge clk);
    #1;
    chk_on = 1'b1;
    check("por_out", out, 0);
    check("por_busy", busy, 0);
    check("por_done", done, 0);
    check("por_borrow", borrow, 0);
    rst = 1'b0;

    // Directed cases with hand-computed results.
    run_op(8'h5A, 8'h23, 1'b0, 0);
    check("t1_out", out, 8'h37);
    check("t1_borrow", borrow, 0);

    run_op(8'h10, 8'h20, 1'b0, 1);
    check("t2_borrow", borrow, 1);
`ifdef SUB_SERIAL_SAT_EN
    check("t2_out", out, 8'h00);
`else
    check("t2_out", out, 8'hF0);
`endif

    run_op(8'h00, 8'h00, 1'b0, 0);
    check("t3_out", out, 8'h00);
    check("t3_borrow", borrow, 0);

    run_op(8'hFF, 8'hFF, 1'b1, 0);
    check("t4_out", out, 8'h00);
    check("t4_borrow", borrow, 0);

    run_op(8'h00, 8'h01, 1'b1, 0);
    check("t5_borrow", borrow, 1);
`ifdef SUB_SERIAL_SAT_EN
    check("t5_out", out, 8'h00);
`else
    check("t5_out", out, 8'hFF);
`endif

    // Reset four cycles into SUB, then a fresh operation.
    @(posedge clk); #1;
    a = 8'h5A; b = 8'h23; en = 1'b1;
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    reset_pulse();
    run_op(8'h80, 8'h01, 1'b0, 0);
    check("t6_out", out, 8'h7F);
    check("t6_borrow", borrow, 0);

    // Hold en five cycles past done, then restart with new operands.
    run_op(8'h33, 8'h11, 1'b0, 5);
    check("t7_out", out, 8'h22);
    run_op(8'h01, 8'h02, 1'b0, 0);
    check("t8_borrow", borrow, 1);

    // Randomised operations, handshake shapes, idle gaps and mid-op resets.
    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 10 == 3) rb = ra;
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
        a = ra; b = rb; en = 1'b1;
        @(posedge clk); #1;
        r = $urandom_range(0, W - 1);
        repeat (r) @(posedge clk);
        reset_pulse();
      end else begin
        run_op(ra, rb, bit'($urandom_range(0, 1)), $urandom_range(0, 4));
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
